// File: rtl/bht_sram_ctrl.sv
// Purpose: 512 x 2-bit branch history table controller on a dual-port SRAM; sweeps the table to weakly-not-taken after reset.
// Latency: lookup result one cycle after pred_req; an update takes three cycles (read, modify, write).
// Backpressure: lookups never stall; updates use upd_req/upd_ready (one in flight); both held off until init_done.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   pred_req/pred_idx               - lookup request; pred_valid/pred_ctr/pred_taken one cycle later
//   upd_req/upd_idx/upd_taken       - counter update, accepted when upd_ready is high
//   init_done                       - table sweep finished, normal operation
//   sram_*0                         - SRAM port 0: init writes, then lookup reads only
//   sram_*1                         - SRAM port 1: update read-modify-write
module bht_sram_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pred_req,
  input  logic [8:0] pred_idx,
  output logic       pred_valid,
  output logic [1:0] pred_ctr,
  output logic       pred_taken,
  input  logic       upd_req,
  input  logic [8:0] upd_idx,
  input  logic       upd_taken,
  output logic       upd_ready,
  output logic       init_done,
  output logic       sram_csb0,
  output logic       sram_web0,
  output logic [8:0] sram_addr0,
  output logic [1:0] sram_din0,
  input  logic [1:0] sram_dout0,
  output logic       sram_csb1,
  output logic       sram_web1,
  output logic [8:0] sram_addr1,
  output logic [1:0] sram_din1,
  input  logic [1:0] sram_dout1
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_FLUSH, S_RUN} state_t;
  typedef enum logic [1:0] {U_IDLE, U_RD, U_WR} ustate_t;

  state_t     state_q, state_d;
  ustate_t    ustate_q, ustate_d;
  logic [8:0] init_cnt_q, init_cnt_d;
  logic [8:0] upd_idx_q, upd_idx_d;
  logic       upd_taken_q, upd_taken_d;
  logic [1:0] upd_ctr_q, upd_ctr_d;
  logic       pred_valid_q, pred_valid_d;
  logic       fwd_q, fwd_d;
  logic [1:0] fwd_dat_q, fwd_dat_d;

  logic       run;
  logic       pred_acc;
  logic       upd_acc;
  logic       upd_wr;
  logic [1:0] upd_new;

  assign run      = (state_q == S_RUN);
  assign pred_acc = run && pred_req;
  assign upd_acc  = run && (ustate_q == U_IDLE) && upd_req;
  assign upd_wr   = run && (ustate_q == U_WR);

  // Saturating 2-bit counter step on the value read back in U_RD.
  always_comb begin
    upd_new = upd_ctr_q;
    if (upd_taken_q) begin
      if (upd_ctr_q != 2'b11) upd_new = upd_ctr_q + 2'd1;
    end else begin
      if (upd_ctr_q != 2'b00) upd_new = upd_ctr_q - 2'd1;
    end
  end

  // Next-state logic for both FSMs and the lookup pipeline.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    ustate_d     = ustate_q;
    upd_idx_d    = upd_idx_q;
    upd_taken_d  = upd_taken_q;
    upd_ctr_d    = upd_ctr_q;
    pred_valid_d = pred_acc;
    // A lookup issued while the update write is on port 1 would read the
    // stale entry (the write commits one edge later), so carry din1 over.
    fwd_d        = pred_acc && upd_wr && (pred_idx == upd_idx_q);
    fwd_dat_d    = upd_new;

    case (state_q)
      S_IDLE:  state_d = S_INIT;
      S_INIT: begin
        init_cnt_d = init_cnt_q + 9'd1;
        if (init_cnt_q == 9'd511) state_d = S_FLUSH;
      end
      // One quiet cycle lets the final init write commit before any read.
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    case (ustate_q)
      U_IDLE: begin
        if (upd_acc) begin
          ustate_d    = U_RD;
          upd_idx_d   = upd_idx;
          upd_taken_d = upd_taken;
        end
      end
      U_RD: begin
        upd_ctr_d = sram_dout1;
        ustate_d  = U_WR;
      end
      default: ustate_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ustate_q     <= U_IDLE;
      init_cnt_q   <= 9'd0;
      upd_idx_q    <= 9'd0;
      upd_taken_q  <= 1'b0;
      upd_ctr_q    <= 2'b00;
      pred_valid_q <= 1'b0;
      fwd_q        <= 1'b0;
      fwd_dat_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      ustate_q     <= ustate_d;
      init_cnt_q   <= init_cnt_d;
      upd_idx_q    <= upd_idx_d;
      upd_taken_q  <= upd_taken_d;
      upd_ctr_q    <= upd_ctr_d;
      pred_valid_q <= pred_valid_d;
      fwd_q        <= fwd_d;
      fwd_dat_q    <= fwd_dat_d;
    end
  end

  // SRAM controls are decoded from flops and the request inputs, so the SRAM
  // samples them at the end of the request cycle; under reset every FSM is
  // idle and the ports fall back to deselected with zero address and data.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = 9'd0;
    sram_din0  = 2'b00;
    sram_csb1  = 1'b1;
    sram_web1  = 1'b1;
    sram_addr1 = 9'd0;
    sram_din1  = 2'b00;

    if (state_q == S_INIT) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = init_cnt_q;
      sram_din0  = 2'b01;
    end else if (pred_acc) begin
      sram_csb0  = 1'b0;
      sram_addr0 = pred_idx;
    end

    if (upd_acc) begin
      sram_csb1  = 1'b0;
      sram_addr1 = upd_idx;
    end else if (upd_wr) begin
      sram_csb1  = 1'b0;
      sram_web1  = 1'b0;
      sram_addr1 = upd_idx_q;
      sram_din1  = upd_new;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_ctr   = !pred_valid_q ? 2'b00 : (fwd_q ? fwd_dat_q : sram_dout0);
  assign pred_taken = pred_ctr[1];
  assign upd_ready  = run && (ustate_q == U_IDLE);
  assign init_done  = run;

endmodule

// File: tb/tb_bht_sram_ctrl.sv
module tb_bht_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pred_req = 1'b0;
  logic [8:0] pred_idx = '0;
  logic       pred_valid;
  logic [1:0] pred_ctr;
  logic       pred_taken;
  logic       upd_req = 1'b0;
  logic [8:0] upd_idx = '0;
  logic       upd_taken = 1'b0;
  logic       upd_ready;
  logic       init_done;
  logic       sram_csb0, sram_web0, sram_csb1, sram_web1;
  logic [8:0] sram_addr0, sram_addr1;
  logic [1:0] sram_din0, sram_din1;
  logic [1:0] sram_dout0 = '0;
  logic [1:0] sram_dout1 = '0;

  bht_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req(pred_req), .pred_idx(pred_idx),
    .pred_valid(pred_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_web1(sram_web1), .sram_addr1(sram_addr1),
    .sram_din1(sram_din1), .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- dual-port SRAM model ----------------
  // Controls sampled at edge E, read data valid after E, write commits at E+1.
  logic [1:0] mem [512];
  logic       s_csb0 = 1'b1, s_web0 = 1'b1, s_csb1 = 1'b1, s_web1 = 1'b1;
  logic [8:0] s_a0 = '0, s_a1 = '0;
  logic [1:0] s_d0 = '0, s_d1 = '0;
  logic       w0_pend = 1'b0, w1_pend = 1'b0;
  logic [8:0] w0_a = '0, w1_a = '0;
  logic [1:0] w0_d = '0, w1_d = '0;

  always @(posedge clk) begin
    if (w0_pend) mem[w0_a] = w0_d;
    if (w1_pend) mem[w1_a] = w1_d;
    w0_pend = 1'b0;
    w1_pend = 1'b0;
    if (!s_csb0) begin
      if (s_web0) sram_dout0 <= mem[s_a0];
      else begin w0_pend = 1'b1; w0_a = s_a0; w0_d = s_d0; end
    end
    if (!s_csb1) begin
      if (s_web1) sram_dout1 <= mem[s_a1];
      else begin w1_pend = 1'b1; w1_a = s_a1; w1_d = s_d1; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [1:0] exp_q [$];
  int dual_wr = 0;
  int p1_wr   = 0;
  int wr_cnt  = 0;
  int wr_bad  = 0;

  always @(negedge clk) begin
    s_csb0 = sram_csb0; s_web0 = sram_web0; s_a0 = sram_addr0; s_d0 = sram_din0;
    s_csb1 = sram_csb1; s_web1 = sram_web1; s_a1 = sram_addr1; s_d1 = sram_din1;
    if (!sram_csb0 && !sram_web0 && !sram_csb1 && !sram_web1) dual_wr++;
    if (!init_done && !sram_csb1 && !sram_web1) p1_wr++;
    if (rst_n && !init_done && !sram_csb0 && !sram_web0) begin
      if (sram_addr0 != wr_cnt[8:0] || sram_din0 != 2'b01) wr_bad++;
      wr_cnt++;
    end
    if (pred_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pred_unexpected: pred_valid=1 with no outstanding lookup, ctr=%b", pred_ctr);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (pred_ctr !== e) begin
          failures++;
          $display("FAIL pred_ctr: got %b expected %b", pred_ctr, e);
        end
        checks++;
        if (pred_taken !== e[1]) begin
          failures++;
          $display("FAIL pred_taken: got %b expected %b", pred_taken, e[1]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         wcyc;
    logic [8:0] idx;
    logic       taken;
  } upd_t;

  logic [1:0] ref_mem [512];
  upd_t       pend [$];
  int         cyc = 0;
  int         rdy_cyc = 0;
  bit         last_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle of stimulus. An accepted update becomes visible to lookups
  // issued in its write cycle (two cycles after acceptance) and later.
  task automatic step(input bit pr, input logic [8:0] pi, input bit ur,
                      input logic [8:0] ui, input bit ut);
    bit exp_rdy;
    @(posedge clk); #1;
    cyc++;
    while (pend.size() > 0 && pend[0].wcyc <= cyc) begin
      upd_t u;
      u = pend.pop_front();
      if (u.taken) ref_mem[u.idx] = (ref_mem[u.idx] == 2'd3) ? 2'd3 : ref_mem[u.idx] + 2'd1;
      else         ref_mem[u.idx] = (ref_mem[u.idx] == 2'd0) ? 2'd0 : ref_mem[u.idx] - 2'd1;
    end
    exp_rdy = (cyc >= rdy_cyc);
    check("upd_ready", {31'd0, upd_ready}, {31'd0, exp_rdy});
    pred_req = pr; pred_idx = pi;
    upd_req = ur; upd_idx = ui; upd_taken = ut;
    if (pr) exp_q.push_back(ref_mem[pi]);
    last_acc = ur && exp_rdy;
    if (last_acc) begin
      pend.push_back('{cyc + 2, ui, ut});
      rdy_cyc = cyc + 3;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic upd(input logic [8:0] idx, input bit t);
    int k;
    k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 10) begin
      step(1'b0, 9'd0, 1'b1, idx, t);
      k++;
    end
    check("upd_accept", {31'd0, last_acc}, 32'd1);
  endtask

  task automatic assert_reset();
    logic [31:0] got;
    #2;
    rst_n = 1'b0;
    pred_req = 1'b0; upd_req = 1'b0;
    #1;
    got = {pred_valid, pred_ctr, pred_taken, upd_ready, init_done,
           sram_csb0, sram_web0, sram_csb1, sram_web1,
           sram_addr0, sram_addr1, sram_din0, sram_din1};
    check("reset_outputs", got,
          {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1111, 9'd0, 9'd0, 2'b00, 2'b00});
    exp_q.delete();
    pend.delete();
    p1_wr = 0; wr_cnt = 0; wr_bad = 0;
  endtask

  // Release reset, optionally abort at INIT cycle abort_n, else check the sweep.
  task automatic init_seq(input int abort_n);
    int  n;
    int  rdy_bad;
    int  bad_ent;
    bit  done;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0; done = 1'b0; rdy_bad = 0;
    while (!done && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (init_done) begin
        done = 1'b1;
      end else if (n == abort_n) begin
        assert_reset();
        return;
      end else begin
        if (upd_ready) rdy_bad++;
        pred_req = 1'($urandom_range(0, 1)); pred_idx = 9'($urandom_range(0, 511));
        upd_req  = 1'($urandom_range(0, 1)); upd_idx  = 9'($urandom_range(0, 511));
        upd_taken = 1'($urandom_range(0, 1));
      end
    end
    pred_req = 1'b0; upd_req = 1'b0;
    check("init_done_cycle", n, 514);
    check("init_write_count", wr_cnt, 512);
    check("init_write_order", wr_bad, 0);
    check("p1_write_outside_run", p1_wr, 0);
    check("ready_during_init", rdy_bad, 0);
    bad_ent = 0;
    for (int i = 0; i < 512; i++) if (mem[i] != 2'b01) bad_ent++;
    check("table_after_init", bad_ent, 0);
    for (int i = 0; i < 512; i++) ref_mem[i] = 2'b01;
    pend.delete();
    cyc = 0;
    rdy_cyc = 0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 2'($urandom_range(0, 3));
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_init_done", {31'd0, init_done}, 32'd0);
    check("reset_upd_ready", {31'd0, upd_ready}, 32'd0);
    check("reset_csb", {30'd0, sram_csb0, sram_csb1}, 32'd3);

    // Abort the sweep at init_cnt = 200, then run it fully.
    init_seq(201);
    init_seq(0);

    // Basic lookup after init.
    step(1'b1, 9'd5, 1'b0, 9'd0, 1'b0);
    idle(2);

    // Three taken then four not-taken updates to index 7, back to back.
    upd(9'd7, 1'b1); upd(9'd7, 1'b1); upd(9'd7, 1'b1);
    idle(3);
    step(1'b1, 9'd7, 1'b0, 9'd0, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) upd(9'd7, 1'b0);
    idle(3);
    step(1'b1, 9'd7, 1'b0, 9'd0, 1'b0);
    idle(1);

    // Forwarding: lookup index 9 in the write cycle of its own update.
    upd(9'd9, 1'b1);
    step(1'b0, 9'd0, 1'b0, 9'd0, 1'b0);
    step(1'b1, 9'd9, 1'b0, 9'd0, 1'b0);
    step(1'b1, 9'd10, 1'b0, 9'd0, 1'b0);
    idle(2);

    // Reset while an update is in its read cycle; it must be dropped.
    upd(9'd20, 1'b1);
    step(1'b0, 9'd0, 1'b0, 9'd0, 1'b0);
    assert_reset();
    init_seq(0);
    step(1'b1, 9'd20, 1'b0, 9'd0, 1'b0);
    idle(2);

    // Random concurrent traffic, biased to a few indices to force collisions.
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] pi, ui;
      pi = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      ui = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), pi, ($urandom_range(0, 9) < 6), ui, 1'($urandom_range(0, 1)));
    end
    idle(4);

    check("outstanding_lookups", exp_q.size(), 0);
    check("dual_port_write", dual_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
